// File: rtl/frame_bank_scheduler_if.sv
// Capture-side byte stream and frame-memory write port of frame_bank_scheduler.
// master: capture path plus memory; slave: the scheduler.
interface frame_bank_scheduler_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                wr_valid;
    logic                wr_sof;
    logic [7:0]          wr_data;
    logic                wr_ready;
    logic                mem_we;
    logic [ADDR_WIDTH:0] mem_waddr;
    logic [7:0]          mem_wdata;

    modport master (
        output wr_valid, wr_sof, wr_data,
        input  wr_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_sof, wr_data,
        output wr_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Ping-pong scheduler for the two-bank thermal frame memory.
// Capture bytes fill one bank; at end of frame the banks swap, but never while
// the (synchronised) SPI chip select shows a readout in progress.
// Optional build macro FRAME_BANK_DROP_EN: instead of stalling capture while
// CS is high at end of frame, the completed frame is discarded and counted.
module frame_bank_scheduler #(
    parameter int ADDR_WIDTH  = 14,
    parameter int FRAME_BYTES = 1536,
    parameter int DROP_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    frame_bank_scheduler_if.slave bus,
    input  logic                  spi_cs,
    output logic                  rd_bank,
    output logic                  frame_ready,
    output logic [DROP_CNT_W-1:0] frames_dropped
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_BYTES - 1);

`ifdef FRAME_BANK_DROP_EN
    typedef enum logic [1:0] {ST_FILL, ST_END} state_t;
`else
    typedef enum logic [1:0] {ST_FILL, ST_END, ST_HOLD} state_t;
`endif

    state_t                state, state_nxt;
    logic                  rdy_en;
    logic                  cs_meta, cs_s, cs_s_d, cs_rise;
    logic                  fill_bank;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_frame;
    logic                  ready, beat, wr_en, last_beat, swap;
    logic [ADDR_WIDTH-1:0] widx;
    logic                  mem_we_r;
    logic [ADDR_WIDTH:0]   mem_waddr_r;
    logic [7:0]            mem_wdata_r;
`ifdef FRAME_BANK_DROP_EN
    logic                  drop;
    logic [DROP_CNT_W-1:0] drop_cnt;
`endif

    assign cs_rise   = cs_s & ~cs_s_d;
    assign ready     = rdy_en && (state == ST_FILL);
    assign beat      = bus.wr_valid & ready;
    // A beat without SOF before any frame has started carries nothing to store.
    assign wr_en     = beat & (bus.wr_sof | in_frame);
    assign widx      = bus.wr_sof ? '0 : idx;
    assign last_beat = wr_en & ~bus.wr_sof & (idx == LAST_IDX);

    assign bus.wr_ready  = ready;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_waddr = mem_waddr_r;
    assign bus.mem_wdata = mem_wdata_r;

    // CS synchroniser, edge history and the one-cycle ready hold-off after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta <= 1'b0;
            cs_s    <= 1'b0;
            cs_s_d  <= 1'b0;
            rdy_en  <= 1'b0;
        end else begin
            cs_meta <= spi_cs;
            cs_s    <= cs_meta;
            cs_s_d  <= cs_s;
            rdy_en  <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_FILL;
        else          state <= state_nxt;
    end

    // Next state plus swap/drop decisions; swapping only ever happens with cs_s low.
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
`ifdef FRAME_BANK_DROP_EN
        drop      = 1'b0;
`endif
        unique case (state)
            ST_FILL: if (last_beat) state_nxt = ST_END;
            ST_END: begin
                if (!cs_s) begin
                    swap      = 1'b1;
                    state_nxt = ST_FILL;
                end else begin
`ifdef FRAME_BANK_DROP_EN
                    drop      = 1'b1;
                    state_nxt = ST_FILL;
`else
                    state_nxt = ST_HOLD;
`endif
                end
            end
`ifndef FRAME_BANK_DROP_EN
            ST_HOLD: begin
                if (!cs_s) begin
                    swap      = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
`endif
            default: state_nxt = ST_FILL;
        endcase
    end

    // Byte indexing, registered memory write, bank swap and frame_ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_r    <= 1'b0;
            mem_waddr_r <= '0;
            mem_wdata_r <= '0;
            idx         <= '0;
            in_frame    <= 1'b0;
            fill_bank   <= 1'b0;
            rd_bank     <= 1'b1;
            frame_ready <= 1'b0;
        end else begin
            mem_we_r <= wr_en;
            if (wr_en) begin
                mem_waddr_r <= {fill_bank, widx};
                mem_wdata_r <= bus.wr_data;
            end
            // The last index is held (not incremented) so it never spills past the frame.
            if (beat && bus.wr_sof) begin
                idx      <= ADDR_WIDTH'(1);
                in_frame <= 1'b1;
            end else if (wr_en) begin
                if (idx == LAST_IDX) in_frame <= 1'b0;
                else                 idx      <= idx + ADDR_WIDTH'(1);
            end
            if (swap) begin
                rd_bank   <= fill_bank;
                fill_bank <= ~fill_bank;
                idx       <= '0;
            end
`ifdef FRAME_BANK_DROP_EN
            if (drop) idx <= '0;
`endif
            if (swap)         frame_ready <= 1'b1;
            else if (cs_rise) frame_ready <= 1'b0;
        end
    end

`ifdef FRAME_BANK_DROP_EN
    // Saturating count of frames discarded because a readout was in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  drop_cnt <= '0;
        else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
    assign frames_dropped = drop_cnt;
`else
    assign frames_dropped = '0;
`endif
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Randomised scoreboard bench for frame_bank_scheduler.
module tb_frame_bank_scheduler;
    localparam int AW = 14;
    localparam int FB = 1536;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spi_cs = 1'b0;
    logic          rd_bank;
    logic          frame_ready;
    logic [DW-1:0] frames_dropped;

    frame_bank_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

    frame_bank_scheduler #(.ADDR_WIDTH(AW), .FRAME_BYTES(FB), .DROP_CNT_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .spi_cs(spi_cs),
        .rd_bank(rd_bank), .frame_ready(frame_ready), .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame bookkeeping state as seen after each clock edge.
    logic [AW+8:0] exp_q[$];
    logic m_ready = 0, m_stall = 0, m_started = 0;
    logic m_fill = 0, m_rd = 1, m_fr = 0;
    logic s1 = 0, s2 = 0, s2d = 0;
    int   m_idx = 0, m_drops = 0, m_frames = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            m_ready = 0; m_stall = 0; m_started = 0;
            m_fill = 0; m_rd = 1; m_fr = 0;
            s1 = 0; s2 = 0; s2d = 0;
            m_idx = 0; m_drops = 0;
        end else begin
            if (m_stall) begin
                if (!s2) begin
                    m_rd = m_fill; m_fill = ~m_fill; m_fr = 1;
                    m_stall = 0; m_idx = 0; m_frames++;
                end
`ifdef FRAME_BANK_DROP_EN
                else begin
                    if (m_drops < (1 << DW) - 1) m_drops++;
                    m_stall = 0; m_idx = 0; m_frames++;
                end
`endif
            end else if (m_ready && bus.wr_valid) begin
                if (bus.wr_sof) begin
                    exp_q.push_back({m_fill, AW'(0), bus.wr_data});
                    m_idx = 1; m_started = 1;
                end else if (m_started) begin
                    exp_q.push_back({m_fill, AW'(m_idx), bus.wr_data});
                    if (m_idx == FB - 1) begin m_stall = 1; m_started = 0; end
                    else m_idx++;
                end
            end
            if (s2 && !s2d) m_fr = 0;
            s2d = s2; s2 = s1; s1 = spi_cs;
            m_ready = !m_stall;
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        logic [AW+8:0] e;
        check("wr_ready", bus.wr_ready, m_ready);
        check("rd_bank", rd_bank, m_rd);
        check("frame_ready", frame_ready, m_fr);
        check("frames_dropped", frames_dropped, m_drops);
        check("mem_we", bus.mem_we, exp_q.size() != 0);
        if (bus.mem_we && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("mem_waddr", bus.mem_waddr, e[AW+8:8]);
            check("mem_wdata", bus.mem_wdata, e[7:0]);
        end
    end

    // Streams bytes until the model has finished `target` frames (or sees a stalled
    // frame end when stop_on_stall); mid_sof>0 restarts the frame once at that index.
    task automatic stream_until(input int target, input int valid_pct, input int mid_sof,
                                input bit rand_mode, input bit stop_on_stall);
        int budget = 30000;
        bit did_mid = 0;
        bit v, sof;
        while (m_frames < target && !(stop_on_stall && m_stall) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            v   = ($urandom_range(0, 99) < valid_pct);
            sof = 0;
            if (!m_started && m_idx == 0)
                sof = rand_mode ? ($urandom_range(0, 7) != 0) : 1'b1;
            else if (mid_sof > 0 && !did_mid && m_idx == mid_sof && m_ready) begin
                sof = 1; did_mid = v;
            end
            bus.wr_valid = v;
            bus.wr_sof   = sof;
            bus.wr_data  = rand_mode ? 8'($urandom) : (sof ? 8'd0 : 8'(m_idx));
            if (rand_mode && $urandom_range(0, 299) == 0) spi_cs = ~spi_cs;
        end
        check("stream_timeout", budget > 0, 1);
        bus.wr_valid = 0;
        bus.wr_sof   = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        bus.wr_valid = 0; bus.wr_sof = 0; bus.wr_data = 0;
        cycles(3);
        #2 reset_n = 1;
        #1 check("ready_after_release", bus.wr_ready, 0);
        cycles(1);
        check("ready_one_cycle_later", bus.wr_ready, 1);

        // Frame 1 into bank 0, CS idle.
        stream_until(1, 100, 0, 0, 0);
        check("f1_rd_bank", rd_bank, 0);
        check("f1_frame_ready", frame_ready, 1);

        // CS rise clears frame_ready three clocks later.
        spi_cs = 1;
        cycles(2);
        check("cs_fr_before", frame_ready, 1);
        cycles(1);
        check("cs_fr_cleared", frame_ready, 0);
        check("cs_rd_bank_held", rd_bank, 0);

        // Frame 2 ends while CS is still high.
        stream_until(m_frames + 1, 90, 0, 0, 1);
        cycles(50);
`ifdef FRAME_BANK_DROP_EN
        check("drop_rd_bank", rd_bank, 0);
        check("drop_count", frames_dropped, 1);
        spi_cs = 0;
        cycles(3);
`else
        check("hold_wr_ready", bus.wr_ready, 0);
        spi_cs = 0;
        cycles(2);
        check("hold_rd_bank_pre", rd_bank, 0);
        cycles(1);
        check("hold_rd_bank", rd_bank, 1);
        check("hold_frame_ready", frame_ready, 1);
        check("hold_wr_ready_after", bus.wr_ready, 1);
`endif

        // Mid-frame SOF restart at byte 700.
        stream_until(m_frames + 1, 85, 700, 0, 0);

        // Random traffic with CS toggling and skipped SOFs.
        stream_until(m_frames + 3, 80, 0, 1, 0);
        spi_cs = 0;

`ifdef FRAME_BANK_DROP_EN
        spi_cs = 1;
        stream_until(m_frames + 5, 100, 0, 0, 0);
        check("drop_saturated", frames_dropped, (1 << DW) - 1);
        spi_cs = 0;
        cycles(4);
`endif

        // Asynchronous reset at byte 800.
        budget = 5000;
        while (m_idx != 800 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            bus.wr_valid = ($urandom_range(0, 3) != 0);
            bus.wr_sof   = (!m_started && m_idx == 0);
            bus.wr_data  = 8'($urandom);
        end
        check("reach_byte_800", budget > 0, 1);
        #2 reset_n = 0;
        #1;
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_waddr", bus.mem_waddr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_rd_bank", rd_bank, 1);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_frames_dropped", frames_dropped, 0);
        bus.wr_valid = 0; bus.wr_sof = 0;
        cycles(2);
        #2 reset_n = 1;
        stream_until(m_frames + 1, 95, 0, 0, 0);
        check("post_rst_rd_bank", rd_bank, 0);
        check("post_rst_frame_ready", frame_ready, 1);

        cycles(5);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
